// File: rtl/des_iter_ed.sv
// Iterative DES core: N_RPC chained rounds per clock behind a four-phase req/ack handshake.
// Optional decrypt path is built only when DES_ITER_DEC_EN is defined; otherwise dec reads as 0.
module des_iter_ed #(
    parameter int N_RPC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        ack,
    input  logic        dec,
    input  logic [63:0] k,
    input  logic [63:0] m,
    output logic [63:0] c
);
    if (N_RPC != 1 && N_RPC != 2 && N_RPC != 4 && N_RPC != 8 && N_RPC != 16) begin : g_bad_n_rpc
        $error("des_iter_ed: N_RPC must be 1, 2, 4, 8 or 16");
    end

    // Permutation tables use DES numbering: entry n selects input bit n counted from the MSB (1-based).
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                 16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                 2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                  19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SBOX_T [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,    0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,    15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,    3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,    13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,    13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,    1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,    13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,    3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,    14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,    11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,    10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,    4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,    13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,    6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,    1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,    2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    function automatic logic [63:0] f_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
        return y;
    endfunction

    function automatic logic [63:0] f_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] f_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
        return y;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
        return y;
    endfunction

    function automatic logic [31:0] f_feistel(input logic [31:0] r, input logic [47:0] key);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[i])];
        x = x ^ key;
        for (int j = 0; j < 8; j++) begin
            b = x[6'(47 - 6 * j) -: 6];
            s[5'(31 - 4 * j) -: 4] = 4'(SBOX_T[9'(64 * j + 16 * int'({b[5], b[0]}) + int'(b[4:1]))]);
        end
        for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[i])];
        return y;
    endfunction

    function automatic logic [55:0] f_rotl(input logic [55:0] cd, input logic one);
        logic [27:0] cc, dd;
        cc = cd[55:28];
        dd = cd[27:0];
        if (one) begin
            cc = {cc[26:0], cc[27]};
            dd = {dd[26:0], dd[27]};
        end else begin
            cc = {cc[25:0], cc[27:26]};
            dd = {dd[25:0], dd[27:26]};
        end
        return {cc, dd};
    endfunction

`ifdef DES_ITER_DEC_EN
    // Undoes the encrypt schedule: no shift before round 0, so the first subkey is K16.
    function automatic logic [55:0] f_rotr(input logic [55:0] cd, input logic [4:0] idx);
        logic [27:0] cc, dd;
        cc = cd[55:28];
        dd = cd[27:0];
        if (idx == 5'd1 || idx == 5'd8 || idx == 5'd15) begin
            cc = {cc[0], cc[27:1]};
            dd = {dd[0], dd[27:1]};
        end else if (idx != 5'd0) begin
            cc = {cc[1:0], cc[27:2]};
            dd = {dd[1:0], dd[27:2]};
        end
        return {cc, dd};
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_l, r_r;
    logic [55:0] r_cd;
    logic [4:0]  r_rnd;
    logic        r_mode;
    logic        r_ack;
    logic [63:0] r_c;
    logic        w_last;

    logic [N_RPC:0][31:0] w_l, w_r;
    logic [N_RPC:0][55:0] w_cd;

    assign w_l[0]  = r_l;
    assign w_r[0]  = r_r;
    assign w_cd[0] = r_cd;

    for (genvar g = 0; g < N_RPC; g++) begin : g_rnd
        logic [4:0]  w_idx;
        logic        w_one;
        logic [55:0] w_cd_n;
        assign w_idx = r_rnd + 5'(g);
        assign w_one = (w_idx == 5'd0) || (w_idx == 5'd1) || (w_idx == 5'd8) || (w_idx == 5'd15);
`ifdef DES_ITER_DEC_EN
        assign w_cd_n = r_mode ? f_rotr(w_cd[g], w_idx) : f_rotl(w_cd[g], w_one);
`else
        assign w_cd_n = f_rotl(w_cd[g], w_one);
`endif
        assign w_cd[g+1] = w_cd_n;
        assign w_l[g+1]  = w_r[g];
        assign w_r[g+1]  = w_l[g] ^ f_feistel(w_r[g], f_pc2(w_cd_n));
    end

`ifndef DES_ITER_DEC_EN
    logic w_unused;
    assign w_unused = ^{dec, r_mode};
`endif

    assign w_last = (r_rnd + 5'(N_RPC)) == 5'd16;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    if (req) w_state_n = RUN;
            RUN:     if (w_last) w_state_n = DONE;
            DONE:    if (!req) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_l    <= '0;
            r_r    <= '0;
            r_cd   <= '0;
            r_rnd  <= '0;
            r_mode <= 1'b0;
            r_ack  <= 1'b0;
            r_c    <= '0;
        end else begin
            case (r_state)
                IDLE: if (req) begin
                    {r_l, r_r} <= f_ip(m);
                    r_cd       <= f_pc1(k);
                    r_rnd      <= '0;
`ifdef DES_ITER_DEC_EN
                    r_mode     <= dec;
`else
                    r_mode     <= 1'b0;
`endif
                end
                RUN: begin
                    r_l   <= w_l[N_RPC];
                    r_r   <= w_r[N_RPC];
                    r_cd  <= w_cd[N_RPC];
                    r_rnd <= r_rnd + 5'(N_RPC);
                    if (w_last) begin
                        // Final round output is taken unswapped, hence R before L into FP.
                        r_c   <= f_fp({w_r[N_RPC], w_l[N_RPC]});
                        r_ack <= 1'b1;
                    end
                end
                DONE: if (!req) r_ack <= 1'b0;
                default: r_ack <= 1'b0;
            endcase
        end
    end

    assign ack = r_ack;
    assign c   = r_c;
endmodule

// File: tb/tb_des_iter_ed.sv
// Directed bench for des_iter_ed: one instance per legal N_RPC (1,2,4,8,16) sharing clk/rst/k/m/dec.
module tb_des_iter_ed;
    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] M1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] ZC = 64'h8CA64DE9C1B123A7;

    logic             clk;
    logic             rst;
    logic             dec;
    logic [63:0]      k, m;
    logic [4:0]       req_v, ack_v;
    logic [4:0][63:0] c_v;
    int               errors = 0;
    int               checks = 0;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        des_iter_ed #(.N_RPC(1 << g)) u_dut (
            .clk (clk),
            .rst (rst),
            .req (req_v[g]),
            .ack (ack_v[g]),
            .dec (dec),
            .k   (k),
            .m   (m),
            .c   (c_v[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    // Drives a request and returns just after the capture edge; inputs are then scrambled.
    task automatic start_op(input int s, input logic [63:0] kk, input logic [63:0] mm, input logic dd);
        k = kk; m = mm; dec = dd; req_v[s] = 1'b1;
        @(posedge clk); #1;
        k = ~kk; m = ~mm; dec = ~dd;
    endtask

    task automatic wait_ack(input int s, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ack_v[s]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_v = '0; k = '0; m = '0; dec = 1'b0;
        #12;
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (ack_v[s] !== 1'b0) begin errors++; $display("FAIL reset_ack[%0d]: got %b want 0", s, ack_v[s]); end
            checks++;
            if (c_v[s] !== 64'h0) begin errors++; $display("FAIL reset_c[%0d]: got %h want 0", s, c_v[s]); end
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_encrypt_handshake();
        int n;
        start_op(0, K1, M1, 1'b0);
        checks++;
        if (ack_v[0] !== 1'b0) begin errors++; $display("FAIL enc_e0_ack: got %b want 0", ack_v[0]); end
        wait_ack(0, n);
        checks++;
        if (n != 16) begin errors++; $display("FAIL enc_latency: got %0d want 16", n); end
        checks++;
        if (c_v[0] !== C1) begin errors++; $display("FAIL enc_c: got %h want %h", c_v[0], C1); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ack_v[0] !== 1'b1 || c_v[0] !== C1) begin
                errors++; $display("FAIL hold[%0d]: got ack=%b c=%h want ack=1 c=%h", i, ack_v[0], c_v[0], C1);
            end
        end
        req_v[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ack_v[0] !== 1'b0) begin errors++; $display("FAIL drop_ack: got %b want 0", ack_v[0]); end
        checks++;
        if (c_v[0] !== C1) begin errors++; $display("FAIL c_retain: got %h want %h", c_v[0], C1); end
    endtask

    task automatic test_decrypt();
        int n;
        int sel [2] = '{0, 2};
        logic [63:0] exp_c;
        foreach (sel[j]) begin
`ifdef DES_ITER_DEC_EN
            start_op(sel[j], K1, C1, 1'b1);
            exp_c = M1;
`else
            start_op(sel[j], K1, M1, 1'b1);
            exp_c = C1;
`endif
            wait_ack(sel[j], n);
            checks++;
            if (n != (16 >> sel[j])) begin errors++; $display("FAIL dec_latency[%0d]: got %0d want %0d", sel[j], n, 16 >> sel[j]); end
            checks++;
            if (c_v[sel[j]] !== exp_c) begin errors++; $display("FAIL dec_c[%0d]: got %h want %h", sel[j], c_v[sel[j]], exp_c); end
            req_v[sel[j]] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_sweep();
        int n;
        for (int s = 0; s < 5; s++) begin
            start_op(s, 64'h0, 64'h0, 1'b0);
            wait_ack(s, n);
            checks++;
            if (n != (16 >> s)) begin errors++; $display("FAIL zero_latency[%0d]: got %0d want %0d", s, n, 16 >> s); end
            checks++;
            if (c_v[s] !== ZC) begin errors++; $display("FAIL zero_c[%0d]: got %h want %h", s, c_v[s], ZC); end
            req_v[s] = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (ack_v[s] !== 1'b0) begin errors++; $display("FAIL zero_drop[%0d]: got %b want 0", s, ack_v[s]); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start_op(0, K1, M1, 1'b0);
        wait_ack(0, n);
        checks++;
        if (c_v[0] !== C1) begin errors++; $display("FAIL b2b_first_c: got %h want %h", c_v[0], C1); end
        req_v[0] = 1'b0;
        @(posedge clk); #1;
        start_op(0, 64'h0, 64'h0, 1'b0);
        wait_ack(0, n);
        checks++;
        if (n != 16) begin errors++; $display("FAIL b2b_latency: got %0d want 16", n); end
        checks++;
        if (c_v[0] !== ZC) begin errors++; $display("FAIL b2b_c: got %h want %h", c_v[0], ZC); end
        req_v[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_no_restart();
        int n;
        int drops = 0;
        start_op(0, K1, M1, 1'b0);
        wait_ack(0, n);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ack_v[0] !== 1'b1) drops++;
        end
        checks++;
        if (drops != 0) begin errors++; $display("FAIL hold_high_ack: got %0d low cycles want 0", drops); end
        checks++;
        if (c_v[0] !== C1) begin errors++; $display("FAIL hold_high_c: got %h want %h", c_v[0], C1); end
        req_v[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        start_op(0, K1, M1, 1'b0);
        repeat (7) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ack_v[0] !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %b want 0", ack_v[0]); end
        checks++;
        if (c_v[0] !== 64'h0) begin errors++; $display("FAIL rstmid_c: got %h want 0", c_v[0]); end
        checks++;
        if (c_v[4] !== 64'h0) begin errors++; $display("FAIL rstmid_c16: got %h want 0", c_v[4]); end
        req_v[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        start_op(0, K1, M1, 1'b0);
        wait_ack(0, n);
        checks++;
        if (n != 16) begin errors++; $display("FAIL rstmid_latency: got %0d want 16", n); end
        checks++;
        if (c_v[0] !== C1) begin errors++; $display("FAIL rstmid_c_after: got %h want %h", c_v[0], C1); end
        req_v[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_early_drop();
        int n = -1;
        start_op(0, K1, M1, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 3) req_v[0] = 1'b0;
            if (ack_v[0]) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != 16) begin errors++; $display("FAIL early_latency: got %0d want 16", n); end
        checks++;
        if (c_v[0] !== C1) begin errors++; $display("FAIL early_c: got %h want %h", c_v[0], C1); end
        @(posedge clk); #1;
        checks++;
        if (ack_v[0] !== 1'b0) begin errors++; $display("FAIL early_pulse: got %b want 0", ack_v[0]); end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (ack_v[0] !== 1'b0) begin errors++; $display("FAIL early_idle: got %b want 0", ack_v[0]); end
    endtask

    initial begin
        test_reset();
        test_encrypt_handshake();
        test_decrypt();
        test_zero_sweep();
        test_back_to_back();
        test_no_restart();
        test_reset_mid();
        test_early_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
